// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/drive bundle: mode/pattern/load/brightness in, led/tick out.
// Purely combinational wiring; no latency of its own; no backpressure (outputs are free-running).
interface led_pattern_gen_if #(
  parameter int NUM_LEDS = 5,
  parameter int PWM_BITS = 4
);
  logic [1:0]          mode;
  logic [NUM_LEDS-1:0] pattern;
  logic                load;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_LEDS-1:0] led;
  logic                tick;

  modport master (
    output mode,
    output pattern,
    output load,
    output brightness,
    input  led,
    input  tick
  );

  modport slave (
    input  mode,
    input  pattern,
    input  load,
    input  brightness,
    output led,
    output tick
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Parametrised LED driver: static/blink/count/scan patterns stepped by a prescaler, with global PWM dimming.
// Latency: led shows new state one clk after it changes (two after load); no backpressure, load always accepted.
module led_pattern_gen #(
  parameter int NUM_LEDS = 5,
  parameter int TICK_DIV = 12000000,
  parameter int PWM_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_COUNT  = 2'd2,
    M_SCAN   = 2'd3
  } mode_e;

  localparam int                  PS_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [NUM_LEDS-1:0] BIT0   = NUM_LEDS'(1);

  mode_e               mode_q;
  logic [NUM_LEDS-1:0] pat_q;
  logic [NUM_LEDS-1:0] state;
  logic                phase;
  logic                dir;
  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] led_q;
  logic                tick_q;

  logic                wrap;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] scan_next;
  logic                dir_next;

  assign wrap   = (presc == PS_MAX);
  assign pwm_on = (bus.brightness == '1) | (pwm_cnt < bus.brightness);

  // Bounce: reverse at either end and move away in the same step, so ends are not repeated.
  always_comb begin
    scan_next = state;
    dir_next  = dir;
    if (NUM_LEDS > 1) begin
      if (dir) begin
        if (state[NUM_LEDS-1]) begin
          dir_next  = 1'b0;
          scan_next = state >> 1;
        end else begin
          scan_next = state << 1;
        end
      end else begin
        if (state[0]) begin
          dir_next  = 1'b1;
          scan_next = state << 1;
        end else begin
          scan_next = state >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= M_STATIC;
      pat_q   <= '0;
      state   <= '0;
      phase   <= 1'b1;
      dir     <= 1'b1;
      presc   <= '0;
      pwm_cnt <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_q   <= state & {NUM_LEDS{pwm_on}};

      if (bus.load) begin
        // A load also swallows any step due this cycle.
        mode_q <= mode_e'(bus.mode);
        pat_q  <= bus.pattern;
        presc  <= '0;
        tick_q <= 1'b0;
        phase  <= 1'b1;
        dir    <= 1'b1;
        case (mode_e'(bus.mode))
          M_STATIC: state <= bus.pattern;
          M_BLINK:  state <= bus.pattern;
          M_COUNT:  state <= '0;
          default:  state <= BIT0;
        endcase
      end else begin
        tick_q <= wrap;
        presc  <= wrap ? '0 : presc + PS_W'(1);
        if (wrap) begin
          case (mode_q)
            M_STATIC: state <= pat_q;
            M_BLINK: begin
              phase <= ~phase;
              state <= phase ? '0 : pat_q;
            end
            M_COUNT:  state <= state + NUM_LEDS'(1);
            default: begin
              state <= scan_next;
              dir   <= dir_next;
            end
          endcase
        end
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule
